// File: rtl/muldiv_unit.sv
// Purpose: iterative RV32M multiply/divide (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), radix-2 shift-add and restoring divide.
// Latency: done 34 cycles after the accepting edge (busy for 33 cycles); divide-by-zero / signed overflow: done 1 cycle after.
// Backpressure: start is sampled only while ready (IDLE or DONE); start while busy is ignored; flush aborts to IDLE without done.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   start, op       - request and funct3 opcode, sampled when ready=1
//   in_a, in_b      - rs1 (dividend / multiplicand), rs2 (divisor / multiplier)
//   flush           - abort the in-flight operation, drops a same-cycle start
//   ready/busy/done - state-derived status; done is a one-cycle pulse
//   result          - registered result, held until the next accepted start completes
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  // Multiplicand for multiplies, divisor for divides.
  logic [XLEN-1:0]     opnd_q, opnd_d;
  // Multiply: {partial product high, multiplier shifting out LSB-first}.
  // Divide:   {partial remainder, dividend shifting out MSB-first / quotient shifting in}.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Accept-time decode
  logic                in_sign_a, in_sign_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf;

  // Iteration datapath
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_shift;
  logic                div_ge;
  logic [2*XLEN-1:0]   div_next;

  // Sign fix-up
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix, rem_fix;

  always_comb begin
    in_sign_a = in_a[XLEN-1] & ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM));
    in_sign_b = in_b[XLEN-1] & ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
    // -0x8000_0000 wraps to 0x8000_0000, which read unsigned is the correct magnitude 2^31.
    mag_a     = in_sign_a ? -in_a : in_a;
    mag_b     = in_sign_b ? -in_b : in_b;
    div_zero  = op[2] && (in_b == '0);
    div_ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
                (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);

    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};

    // Trial subtract: shifted remainder is XLEN+1 bits; when it is >= divisor the
    // difference is below the divisor, so the low XLEN bits hold it exactly.
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_next  = div_ge ? {div_shift[XLEN-1:0] - opnd_q, acc_q[XLEN-2:0], 1'b1}
                       : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix   = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_d     = op;
            sign_a_d = in_sign_a;
            sign_b_d = in_sign_b;
            cnt_d    = '0;
            opnd_d   = op[2] ? mag_b : mag_a;
            acc_d    = {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
            if (div_zero) begin
              result_d = op[1] ? in_a : '1;
              state_d  = S_DONE;
            end else if (div_ovf) begin
              result_d = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              state_d  = S_DONE;
            end else begin
              state_d  = S_CALC;
            end
          end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          case (op_q)
            OP_MUL:                       result_d = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result_d = quot_fix;
            OP_REM, OP_REMU:              result_d = rem_fix;
            default:                      result_d = result_q;
          endcase
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit executing the eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over multiple cycles with a start/busy/done handshake. It sits in the execute stage beside the single-cycle ALU. The pipeline stalls while `busy` is high and captures `result` on `done`. It is the sequential counterpart to the ALU's disabled M-extension path and uses radix-2 shift-add / restoring-division datapaths.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` input 1: clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when `ready`=1.
- `op` input 3: funct3 encoding. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `in_a` input 32: rs1 operand (dividend / multiplicand).
- `in_b` input 32: rs2 operand (divisor / multiplier).
- `flush` input 1: abort the in-flight operation (pipeline flush).
- `ready` output 1: unit can accept `start` this cycle.
- `busy` output 1: operation in progress; pipeline stalls.
- `done` output 1: single-cycle pulse; `result` valid.
- `result` output 32: final value; held until the next accepted `start`.

## Operation
- States: IDLE, CALC, FIX, DONE. `ready` = (IDLE or DONE). `busy` = (CALC or FIX). `done` = (DONE).
- Accept: `start`=1 and `ready`=1. The edge latches `op`, the operand magnitudes, the sign flags, and clears the 6-bit iteration counter.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: `in_a` signed, `in_b` unsigned.
  - MUL, MULHU, DIVU, REMU: both unsigned.
  - The magnitude of 0x8000_0000 is 2^31 and is held unsigned in 32 bits.
- Multiply (CALC): 32 shift-add iterations on a 64-bit accumulator, LSB-first on the multiplier.
- Divide (CALC): 32 restoring iterations, MSB-first. Each iteration does a 33-bit trial subtract, producing a quotient bit and a partial remainder.
- FIX: one cycle.
  - Negate the product if sign_a XOR sign_b.
  - Negate the quotient if sign_a XOR sign_b.
  - Negate the remainder if sign_a.
  - Select the output: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register `result`, then go to DONE.
- Special cases are decided at accept. The unit goes IDLE→DONE directly, skipping CALC and FIX.
  - Divide by zero (`in_b`=0, any div/rem op): DIV/DIVU → 0xFFFF_FFFF; REM/REMU → `in_a`.
  - Signed overflow (DIV/REM with `in_a`=0x8000_0000, `in_b`=0xFFFF_FFFF): DIV → 0x8000_0000; REM → 0.
- DONE lasts one cycle.
  - It returns to IDLE, or, if `start`=1 in DONE, it accepts the new operation (back-to-back issue).
- `start` while `busy` is ignored; latched operands are unaffected.
- `flush` has priority over `start` and over the state progression.
  - Any state goes to IDLE on the next edge. No `done` pulse is issued. `result` keeps its previous value.
  - A `start` in the same cycle as `flush` is dropped.
- `reset` has priority over `flush`.
  - State → IDLE, `result`=0, `done`=0, `busy`=0, `ready`=1, counter=0, internal registers cleared.
  - Reset mid-operation discards the operation silently.

## Timing
- Accept at edge k:
  - CALC occupies cycles k+1…k+32; the counter runs 0→31, and CALC exits when the counter reaches 31.
  - FIX occupies cycle k+33.
  - `done`=1 and `result` is valid during cycle k+34.
- Special case: `done`=1 during cycle k+1.
- `busy` is high for exactly 33 cycles on a normal operation and 0 cycles on a special case.
- Back-to-back: a `start` sampled during DONE gives CALC starting the next cycle, with no idle bubble.
- All outputs are registered or derived only from state; there is no combinational path from inputs to `done`, `busy`, or `result`. `ready` depends on state only.

## Test plan
- MUL in_a=0xFFFF_FFFF (-1), in_b=5 → `done` at k+34, result=0xFFFF_FFFB. Same operands with MULHU → 0x0000_0004; with MULH → 0xFFFF_FFFF.
- MULHSU in_a=0x8000_0000, in_b=0xFFFF_FFFF → 0x8000_0000. MULH with 0x8000_0000 × 0x8000_0000 → 0x4000_0000.
- DIV -7/2 → 0xFFFF_FFFD (-3). REM -7/2 → 0xFFFF_FFFF (-1). DIVU 0xFFFF_FFFF/2 → 0x7FFF_FFFF. REMU 100/7 → 2.
- Divide by zero: DIV 42/0 → 0xFFFF_FFFF and REM 42/0 → 42, both with `done` at k+1 and `busy` never asserted. Overflow: DIV 0x8000_0000/-1 → 0x8000_0000; REM → 0.
- Flush at k+10 of a DIV → IDLE at k+11, no `done`, `result` unchanged. A `start` during busy is ignored. A `start` during DONE runs the next op with `done` 34 cycles later.
- Reset asserted mid-CALC → next cycle all outputs at reset values (`result`=0, `ready`=1). A subsequent MUL 3×4 → 12.
